// File: rtl/sdu_rx_avg.sv
// Receive-side averager: records rec_len samples per pass into a bin RAM, sums num_avg passes,
// then plays the summed bins back over valid/ready. Define SDU_RX_SAT_EN for saturating sums.
module sdu_rx_avg #(
  parameter int ADC_WIDTH  = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH:0]   rec_len,
  input  logic [15:0]           num_avg,
  input  logic [ADC_WIDTH-1:0]  adc_in,
  input  logic                  adc_valid,
  output logic                  sdu_rx_en,
  output logic                  seq_done_strobe,
  output logic                  ave_done_strobe,
  output logic                  busy,
  output logic [ACC_WIDTH-1:0]  rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, RECORD, WAIT_TRIG, PLAYBACK} state_t;
  state_t state_reg, state_next;

  logic [ADDR_WIDTH:0]   rec_len_reg, bin_idx_reg, pb_idx_reg, pb_idx_plus;
  logic [15:0]           num_avg_reg, pass_cnt_reg;
  logic                  pb_arm_reg, rx_valid_reg, seq_strobe_reg, ave_strobe_reg;

  logic                  cfg_legal, accept, last_sample, final_pass, pb_xfer, pb_last;

  logic                  wr_valid_reg, wr_first_reg;
  logic [ADDR_WIDTH-1:0] wr_addr_reg, rd_addr;
  logic [ADC_WIDTH-1:0]  wr_sample_reg;
  logic [ACC_WIDTH-1:0]  sample_ext, acc_result, wr_data, ram_q;
  logic [ACC_WIDTH-1:0]  mem [DEPTH];

  assign cfg_legal   = (rec_len != '0) && (!rec_len[ADDR_WIDTH] || rec_len[ADDR_WIDTH-1:0] == '0)
                       && (num_avg != '0);
  assign accept      = (state_reg == RECORD) && adc_valid && !abort;
  assign last_sample = (bin_idx_reg + 1'b1) == rec_len_reg;
  assign final_pass  = (pass_cnt_reg + 16'd1) == num_avg_reg;
  assign pb_idx_plus = pb_idx_reg + 1'b1;
  assign pb_xfer     = (state_reg == PLAYBACK) && rx_valid_reg && rx_ready && !abort;
  assign pb_last     = pb_idx_plus == rec_len_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:      if (start && cfg_legal) state_next = RECORD;
        RECORD:    if (accept && last_sample) state_next = final_pass ? PLAYBACK : WAIT_TRIG;
        WAIT_TRIG: if (start) state_next = RECORD;
        PLAYBACK:  if (pb_xfer && pb_last) state_next = IDLE;
        default:   state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rec_len_reg    <= '0;
      num_avg_reg    <= '0;
      pass_cnt_reg   <= '0;
      bin_idx_reg    <= '0;
      pb_idx_reg     <= '0;
      pb_arm_reg     <= 1'b0;
      rx_valid_reg   <= 1'b0;
      seq_strobe_reg <= 1'b0;
      ave_strobe_reg <= 1'b0;
    end else begin
      seq_strobe_reg <= 1'b0;
      ave_strobe_reg <= 1'b0;
      if (abort) begin
        rx_valid_reg <= 1'b0;
        pb_arm_reg   <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start && cfg_legal) begin
              rec_len_reg  <= rec_len;
              num_avg_reg  <= num_avg;
              pass_cnt_reg <= '0;
              bin_idx_reg  <= '0;
            end
          end
          RECORD: begin
            if (accept) begin
              bin_idx_reg <= bin_idx_reg + 1'b1;
              if (last_sample) begin
                pass_cnt_reg <= pass_cnt_reg + 16'd1;
                if (final_pass) begin
                  ave_strobe_reg <= 1'b1;
                  pb_idx_reg     <= '0;
                  pb_arm_reg     <= 1'b0;
                end else begin
                  seq_strobe_reg <= 1'b1;
                end
              end
            end
          end
          WAIT_TRIG: begin
            if (start) bin_idx_reg <= '0;
          end
          PLAYBACK: begin
            // The first playback cycle overlaps the final bin write, so its read is discarded.
            if (!pb_arm_reg) begin
              pb_arm_reg <= 1'b1;
            end else if (!rx_valid_reg) begin
              rx_valid_reg <= 1'b1;
            end else if (pb_xfer) begin
              pb_idx_reg <= pb_idx_plus;
              if (pb_last) rx_valid_reg <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Accumulate pipeline: the bin is read when the sample is accepted, written one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_valid_reg <= 1'b0;
    end else begin
      wr_valid_reg <= accept;
    end
    wr_addr_reg   <= bin_idx_reg[ADDR_WIDTH-1:0];
    wr_sample_reg <= adc_in;
    wr_first_reg  <= (pass_cnt_reg == '0);
  end

  genvar gi;
  generate
    for (gi = 0; gi < ACC_WIDTH; gi++) begin : g_sext
      if (gi < ADC_WIDTH) begin : g_low
        assign sample_ext[gi] = wr_sample_reg[gi];
      end else begin : g_high
        assign sample_ext[gi] = wr_sample_reg[ADC_WIDTH-1];
      end
    end
  endgenerate

`ifdef SDU_RX_SAT_EN
  logic signed [ACC_WIDTH:0] sum_wide;
  assign sum_wide = $signed({ram_q[ACC_WIDTH-1], ram_q}) + $signed({sample_ext[ACC_WIDTH-1], sample_ext});

  always_comb begin
    acc_result = sum_wide[ACC_WIDTH-1:0];
    if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]) begin
      acc_result = sum_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end
`else
  assign acc_result = ram_q + sample_ext;
`endif

  assign wr_data = wr_first_reg ? sample_ext : acc_result;

  // During playback the address advances on a transfer so the next bin lands one cycle later.
  always_comb begin
    rd_addr = bin_idx_reg[ADDR_WIDTH-1:0];
    if (state_reg == PLAYBACK) begin
      rd_addr = pb_xfer ? pb_idx_plus[ADDR_WIDTH-1:0] : pb_idx_reg[ADDR_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_valid_reg) mem[wr_addr_reg] <= wr_data;
    ram_q <= mem[rd_addr];
  end

  assign sdu_rx_en       = (state_reg == RECORD);
  assign busy            = (state_reg != IDLE);
  assign seq_done_strobe = seq_strobe_reg;
  assign ave_done_strobe = ave_strobe_reg;
  assign rx_valid        = rx_valid_reg;
  assign rx_data         = rx_valid_reg ? ram_q : '0;

endmodule

// File: tb/tb_sdu_rx_avg.sv
// Self-checking bench for sdu_rx_avg: randomized runs against a per-bin running-sum model,
// plus a narrow-accumulator instance for overflow behaviour.
module tb_sdu_rx_avg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, abort, adc_valid, rx_ready;
  logic [10:0] rec_len;
  logic [15:0] num_avg, adc_in;
  logic        sdu_rx_en, seq_done_strobe, ave_done_strobe, busy, rx_valid;
  logic [31:0] rx_data;

  logic        o_start, o_abort, o_adc_valid, o_rx_ready;
  logic [2:0]  o_rec_len;
  logic [15:0] o_num_avg, o_adc_in;
  logic        o_sdu_rx_en, o_seq_done_strobe, o_ave_done_strobe, o_busy, o_rx_valid;
  logic [16:0] o_rx_data;

  sdu_rx_avg dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .rec_len(rec_len),
    .num_avg(num_avg), .adc_in(adc_in), .adc_valid(adc_valid), .sdu_rx_en(sdu_rx_en),
    .seq_done_strobe(seq_done_strobe), .ave_done_strobe(ave_done_strobe), .busy(busy),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  sdu_rx_avg #(.ADC_WIDTH(16), .ACC_WIDTH(17), .ADDR_WIDTH(2)) dut_ovf (
    .clk(clk), .reset(reset), .start(o_start), .abort(o_abort), .rec_len(o_rec_len),
    .num_avg(o_num_avg), .adc_in(o_adc_in), .adc_valid(o_adc_valid), .sdu_rx_en(o_sdu_rx_en),
    .seq_done_strobe(o_seq_done_strobe), .ave_done_strobe(o_ave_done_strobe), .busy(o_busy),
    .rx_data(o_rx_data), .rx_valid(o_rx_valid), .rx_ready(o_rx_ready)
  );

  int      n_checks = 0, n_pass = 0;
  int      seq_cnt = 0, ave_cnt = 0, first_lat = -1, hold_viol = 0;
  bit      timed_out;
  int      stim [1024];
  longint  model [1024];
  int      got_q [$];

  // Fit an exact sum into a signed w-bit accumulator, clamping or wrapping.
  function automatic longint fit(input longint v, input int w);
    longint hi, lo, m, r;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    m  = longint'(1) <<< w;
`ifdef SDU_RX_SAT_EN
    r = (v > hi) ? hi : ((v < lo) ? lo : v);
`else
    r = v % m;
    if (r < 0) r = r + m;
    if (r > hi) r = r - m;
`endif
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
    if (seq_done_strobe === 1'b1) seq_cnt++;
    if (ave_done_strobe === 1'b1) ave_cnt++;
  endtask

  task automatic model_clear();
    for (int k = 0; k < 1024; k++) model[k] = 0;
    seq_cnt = 0;
    ave_cnt = 0;
  endtask

  task automatic do_start(input int rl, input int na);
    rec_len = 11'(rl);
    num_avg = 16'(na);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int rl, input int gap_pct);
    int i;
    i = 0;
    while (i < rl) begin
      if (int'($urandom_range(99)) < gap_pct) begin
        adc_valid = 1'b0;
        adc_in = 16'($urandom);
      end else begin
        adc_valid = 1'b1;
        adc_in = 16'(stim[i]);
        i++;
      end
      tick();
    end
    adc_valid = 1'b0;
  endtask

  task automatic do_pass(input int rl, input int na, input int gap_pct);
    do_start(rl, na);
    feed(rl, gap_pct);
    for (int k = 0; k < rl; k++) model[k] = fit(model[k] + longint'(stim[k]), 32);
  endtask

  task automatic collect(input int n, input int mode);
    int cycles;
    bit prev_stall;
    logic [31:0] prev_data;
    cycles = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    got_q.delete();
    first_lat = -1;
    hold_viol = 0;
    while (got_q.size() < n && cycles < 4000) begin
      if (first_lat < 0 && rx_valid === 1'b1) first_lat = cycles;
      if (prev_stall && (rx_valid !== 1'b1 || rx_data !== prev_data)) hold_viol++;
      case (mode)
        0: rx_ready = 1'b1;
        1: rx_ready = (cycles % 2 == 0);
        default: rx_ready = 1'($urandom_range(1));
      endcase
      prev_stall = (rx_valid === 1'b1) && !rx_ready;
      prev_data = rx_data;
      if (rx_valid === 1'b1 && rx_ready) got_q.push_back(int'($signed(rx_data)));
      tick();
      cycles++;
    end
    rx_ready = 1'b0;
    timed_out = (got_q.size() < n);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    rec_len = 11'd4;
    num_avg = 16'd1;
    tick();
    tick();
    n_checks++;
    if ({busy, sdu_rx_en, seq_done_strobe, ave_done_strobe, rx_valid} !== 5'b0)
      $display("FAIL reset_flags: got %b expected 00000", {busy, sdu_rx_en, seq_done_strobe, ave_done_strobe, rx_valid});
    else n_pass++;
    n_checks++;
    if (rx_data !== 32'd0) $display("FAIL reset_rx_data: got %0h expected 0", rx_data);
    else n_pass++;
    start = 1'b0;
    reset = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_idle_after: busy got %b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_basic();
    int exp_v [4] = '{15, -6, 21, 0};
    model_clear();
    stim[0] = 5; stim[1] = -2; stim[2] = 7; stim[3] = 0;
    for (int p = 0; p < 3; p++) begin
      do_pass(4, 3, 0);
      if (p == 0) begin
        adc_valid = 1'b1;
        adc_in = 16'd1000;
        repeat (3) tick();
        adc_valid = 1'b0;
        n_checks++;
        if (sdu_rx_en !== 1'b0 || busy !== 1'b1)
          $display("FAIL basic_wait_trig: got en=%b busy=%b expected en=0 busy=1", sdu_rx_en, busy);
        else n_pass++;
      end
    end
    n_checks++;
    if (ave_done_strobe !== 1'b1) $display("FAIL basic_ave_strobe_now: got %b expected 1", ave_done_strobe);
    else n_pass++;
    n_checks++;
    if (seq_cnt != 2 || ave_cnt != 1)
      $display("FAIL basic_strobes: got seq=%0d ave=%0d expected seq=2 ave=1", seq_cnt, ave_cnt);
    else n_pass++;
    collect(4, 0);
    n_checks++;
    if (timed_out || first_lat < 0 || first_lat > 3)
      $display("FAIL basic_latency: got %0d cycles (timeout=%0b) expected <=3", first_lat, timed_out);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (k >= got_q.size()) $display("FAIL basic_bin%0d: got none expected %0d", k, exp_v[k]);
      else if (got_q[k] != exp_v[k]) $display("FAIL basic_bin%0d: got %0d expected %0d", k, got_q[k], exp_v[k]);
      else n_pass++;
    end
    n_checks++;
    if (busy !== 1'b0 || rx_valid !== 1'b0)
      $display("FAIL basic_end_idle: got busy=%b rx_valid=%b expected 0 0", busy, rx_valid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int errs;
    model_clear();
    for (int k = 0; k < 8; k++) stim[k] = int'($signed(16'($urandom)));
    for (int p = 0; p < 2; p++) do_pass(8, 2, 0);
    collect(8, 1);
    errs = 0;
    for (int k = 0; k < got_q.size(); k++) if (longint'(got_q[k]) != model[k]) errs++;
    n_checks++;
    if (timed_out || got_q.size() != 8 || errs != 0)
      $display("FAIL bp_order: got %0d words, %0d wrong, expected 8 words all matching", got_q.size(), errs);
    else n_pass++;
    n_checks++;
    if (hold_viol != 0) $display("FAIL bp_hold: got %0d unstable stalls expected 0", hold_viol);
    else n_pass++;
  endtask

  task automatic test_gapped();
    int errs;
    model_clear();
    for (int k = 0; k < 1024; k++) stim[k] = k;
    for (int p = 0; p < 2; p++) do_pass(1024, 2, 50);
    collect(1024, 0);
    errs = 0;
    for (int k = 0; k < got_q.size(); k++) if (got_q[k] != 2 * k) errs++;
    n_checks++;
    if (timed_out || got_q.size() != 1024 || errs != 0)
      $display("FAIL gapped_bins: got %0d words, %0d wrong, expected 1024 words of 2k", got_q.size(), errs);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL gapped_idle: busy got %b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_random();
    int rl, na, errs;
    for (int it = 0; it < 6; it++) begin
      rl = int'($urandom_range(1, 64));
      na = int'($urandom_range(1, 4));
      model_clear();
      for (int p = 0; p < na; p++) begin
        for (int k = 0; k < rl; k++) stim[k] = int'($signed(16'($urandom)));
        do_pass(rl, na, 30);
      end
      n_checks++;
      if (seq_cnt != na - 1 || ave_cnt != 1)
        $display("FAIL rand%0d_strobes: got seq=%0d ave=%0d expected seq=%0d ave=1", it, seq_cnt, ave_cnt, na - 1);
      else n_pass++;
      collect(rl, 2);
      errs = 0;
      for (int k = 0; k < got_q.size(); k++) if (longint'(got_q[k]) != model[k]) errs++;
      n_checks++;
      if (timed_out || got_q.size() != rl || errs != 0 || hold_viol != 0)
        $display("FAIL rand%0d_data: got %0d words, %0d wrong, %0d unstable; expected %0d words ok",
                 it, got_q.size(), errs, hold_viol, rl);
      else n_pass++;
    end
  endtask

  task automatic run_nines(input string tag);
    model_clear();
    stim[0] = 9;
    stim[1] = 9;
    do_pass(2, 1, 0);
    collect(2, 0);
    n_checks++;
    if (timed_out || got_q.size() != 2 || got_q[0] != 9 || got_q[1] != 9)
      $display("FAIL %s_rerun: got %0d words first=%0d expected 9,9", tag, got_q.size(),
               (got_q.size() > 0) ? got_q[0] : -1);
    else n_pass++;
  endtask

  task automatic test_abort();
    model_clear();
    for (int k = 0; k < 4; k++) stim[k] = 100 + k;
    do_pass(4, 3, 0);
    do_start(4, 3);
    feed(2, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if ({busy, sdu_rx_en, seq_done_strobe, ave_done_strobe, rx_valid} !== 5'b0)
      $display("FAIL abort_state: got %b expected 00000", {busy, sdu_rx_en, seq_done_strobe, ave_done_strobe, rx_valid});
    else n_pass++;
    run_nines("abort");
  endtask

  task automatic test_reset_playback();
    model_clear();
    for (int k = 0; k < 4; k++) stim[k] = 50;
    for (int p = 0; p < 2; p++) do_pass(4, 2, 0);
    collect(1, 0);
    reset = 1'b1;
    tick();
    n_checks++;
    if (rx_valid !== 1'b0 || busy !== 1'b0 || rx_data !== 32'd0)
      $display("FAIL rstpb_outputs: got valid=%b busy=%b data=%0h expected 0 0 0", rx_valid, busy, rx_data);
    else n_pass++;
    reset = 1'b0;
    tick();
    run_nines("rstpb");
  endtask

  task automatic test_illegal();
    int rls [3] = '{0, 4, 1025};
    int nas [3] = '{3, 0, 1};
    for (int i = 0; i < 3; i++) begin
      do_start(rls[i], nas[i]);
      n_checks++;
      if (busy !== 1'b0) $display("FAIL illegal%0d_busy: got %b expected 0", i, busy);
      else n_pass++;
    end
  endtask

  task automatic test_start_in_record();
    int errs;
    model_clear();
    for (int k = 0; k < 6; k++) stim[k] = 10 * (k + 1);
    do_start(6, 2);
    for (int i = 0; i < 6; i++) begin
      adc_valid = 1'b1;
      adc_in = 16'(stim[i]);
      start = (i == 2);
      if (i == 2) begin
        rec_len = 11'd2;
        num_avg = 16'd1;
      end
      tick();
    end
    start = 1'b0;
    adc_valid = 1'b0;
    for (int k = 0; k < 6; k++) model[k] = fit(model[k] + longint'(stim[k]), 32);
    n_checks++;
    if (seq_cnt != 1 || ave_cnt != 0 || sdu_rx_en !== 1'b0 || busy !== 1'b1)
      $display("FAIL rec_start_pass0: got seq=%0d ave=%0d en=%b busy=%b expected 1 0 0 1",
               seq_cnt, ave_cnt, sdu_rx_en, busy);
    else n_pass++;
    do_pass(6, 2, 0);
    collect(6, 0);
    errs = 0;
    for (int k = 0; k < got_q.size(); k++) if (longint'(got_q[k]) != model[k]) errs++;
    n_checks++;
    if (timed_out || got_q.size() != 6 || errs != 0 || ave_cnt != 1)
      $display("FAIL rec_start_data: got %0d words, %0d wrong, ave=%0d expected 6 words ok ave=1",
               got_q.size(), errs, ave_cnt);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int ovf_q [$];
    int cycles;
    int exp0, exp1;
`ifdef SDU_RX_SAT_EN
    exp0 = 65535;
    exp1 = -65536;
`else
    exp0 = -4;
    exp1 = 0;
`endif
    o_rec_len = 3'd2;
    o_num_avg = 16'd4;
    for (int p = 0; p < 4; p++) begin
      o_start = 1'b1;
      tick();
      o_start = 1'b0;
      o_adc_valid = 1'b1;
      o_adc_in = 16'h7fff;
      tick();
      o_adc_in = 16'h8000;
      tick();
      o_adc_valid = 1'b0;
    end
    n_checks++;
    if (o_ave_done_strobe !== 1'b1) $display("FAIL ovf_ave_strobe: got %b expected 1", o_ave_done_strobe);
    else n_pass++;
    o_rx_ready = 1'b1;
    cycles = 0;
    while (ovf_q.size() < 2 && cycles < 20) begin
      if (o_rx_valid === 1'b1) ovf_q.push_back(int'($signed(o_rx_data)));
      tick();
      cycles++;
    end
    o_rx_ready = 1'b0;
    n_checks++;
    if (ovf_q.size() != 2 || ovf_q[0] != exp0)
      $display("FAIL ovf_pos: got %0d words first=%0d expected %0d", ovf_q.size(),
               (ovf_q.size() > 0) ? ovf_q[0] : 0, exp0);
    else n_pass++;
    n_checks++;
    if (ovf_q.size() != 2 || ovf_q[1] != exp1)
      $display("FAIL ovf_neg: got %0d words second=%0d expected %0d", ovf_q.size(),
               (ovf_q.size() > 1) ? ovf_q[1] : 0, exp1);
    else n_pass++;
    n_checks++;
    if (o_busy !== 1'b0) $display("FAIL ovf_idle: busy got %b expected 0", o_busy);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; adc_valid = 1'b0; rx_ready = 1'b0;
    rec_len = '0; num_avg = '0; adc_in = '0;
    o_start = 1'b0; o_abort = 1'b0; o_adc_valid = 1'b0; o_rx_ready = 1'b0;
    o_rec_len = '0; o_num_avg = '0; o_adc_in = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_gapped();
    test_random();
    test_abort();
    test_reset_playback();
    test_illegal();
    test_start_in_record();
    test_overflow();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sdu_rx_avg.md
SDU_RX_AVG -- requirements
Module: sdu_rx_avg

Interface
REQ-001 SHALL provide parameter ADC_WIDTH, 16, signed ADC sample width.
REQ-002 SHALL provide parameter ACC_WIDTH, 32, accumulator and output width; SHALL satisfy ACC_WIDTH >= ADC_WIDTH+1.
REQ-003 SHALL provide parameter ADDR_WIDTH, 10, bin address width; DEPTH = 2^ADDR_WIDTH bins.
REQ-004 SHALL provide port: clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL provide port: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL provide port: start  input  1  trigger pulse; begins one acquisition pass.
REQ-007 SHALL provide port: abort  input  1  cancels the run and returns to IDLE.
REQ-008 SHALL provide port: rec_len  input  ADDR_WIDTH+1  samples per pass, legal range 1..DEPTH.
REQ-009 SHALL provide port: num_avg  input  16  passes per run, legal range 1..65535.
REQ-010 SHALL provide port: adc_in  input  ADC_WIDTH  two's-complement sample.
REQ-011 SHALL provide port: adc_valid  input  1  adc_in qualifier.
REQ-012 SHALL provide port: sdu_rx_en  output  1  high while in RECORD.
REQ-013 SHALL provide port: seq_done_strobe  output  1  one-cycle pulse at the end of a non-final pass.
REQ-014 SHALL provide port: ave_done_strobe  output  1  one-cycle pulse at the end of the final pass.
REQ-015 SHALL provide port: busy  output  1  high in any state other than IDLE.
REQ-016 SHALL provide port: rx_data  output  ACC_WIDTH  averaged bin value.
REQ-017 SHALL provide ports: rx_valid  output  1, and rx_ready  input  1; valid/ready playback handshake.

Function
REQ-018 SHALL implement the states IDLE, RECORD, WAIT_TRIG and PLAYBACK.
- Uses one DEPTH x ACC_WIDTH RAM.
- RAM read latency is 1 cycle.
REQ-019 In IDLE, start with legal rec_len and num_avg SHALL latch both values, clear pass_cnt and bin_idx, and enter RECORD on the next cycle.
- Illegal values: start is ignored and the block stays in IDLE.
REQ-020 In RECORD, each cycle with adc_valid=1 SHALL accept one sample into bin bin_idx and increment bin_idx.
- Cycles with adc_valid=0 are stalls.
REQ-021 Bin update SHALL be: pass 0 writes sext(adc_in); later passes write the stored bin value + sext(adc_in).
- The write completes no later than 2 cycles after the sample is accepted.
- The accumulation is correct under back-to-back adc_valid.
REQ-022 After accepting rec_len samples, the block SHALL increment pass_cnt.
- Non-final pass: pulse seq_done_strobe and enter WAIT_TRIG.
- Final pass (pass_cnt reaches num_avg): pulse ave_done_strobe and enter PLAYBACK.
REQ-023 In WAIT_TRIG, start SHALL clear bin_idx and re-enter RECORD; adc_valid SHALL be ignored.
REQ-024 In PLAYBACK, the block SHALL present bins 0..rec_len-1 in order on rx_data, with rx_valid=1.
- First rx_valid within 3 cycles of ave_done_strobe.
- A transfer occurs on rx_valid and rx_ready.
- rx_data and rx_valid are held stable while rx_ready=0.
REQ-025 The final PLAYBACK transfer SHALL return the block to IDLE on the next cycle, with rx_valid=0.
REQ-026 abort SHALL take priority over every other event: next state IDLE, and all strobes and rx_valid deasserted on the next cycle.
REQ-027 start SHALL be ignored in RECORD and PLAYBACK.
- adc_valid is ignored outside RECORD.
- rec_len and num_avg changes after the latch have no effect.
REQ-028 Accumulation SHALL be in signed ACC_WIDTH two's complement; overflow behaviour is governed by REQ-032.

Reset
REQ-029 reset SHALL force IDLE and clear pass_cnt and bin_idx.
- All outputs go to 0: sdu_rx_en, both strobes, busy, rx_valid, rx_data.
REQ-030 Reset mid-run SHALL abandon the run; the RAM is not cleared, because pass 0 overwrites every bin used.
REQ-031 reset SHALL take priority over abort and start.

Configuration
REQ-032 Macro SDU_RX_SAT_EN SHALL select the overflow behaviour of accumulation.
- Defined: results clamp to +(2^(ACC_WIDTH-1)-1) and -2^(ACC_WIDTH-1).
- Undefined: results wrap modulo 2^ACC_WIDTH.
- Either way, the interface and timing are identical.

Verification
REQ-033 Basic averaging: rec_len=4, num_avg=3, adc_in=5,-2,7,0 each pass. Required: 2 seq_done_strobes, 1 ave_done_strobe, rx_data 15,-6,21,0, then IDLE.
REQ-034 Backpressure: rec_len=8, rx_ready toggled 1/0 every cycle. Required: 8 transfers in order, with rx_data held constant during every ready-low cycle.
REQ-035 Gapped input: adc_valid 50% random, rec_len=DEPTH, num_avg=2, adc_in=bin index. Required: bin k reads 2k.
REQ-036 Overflow: ADC_WIDTH=16, ACC_WIDTH=17, num_avg=4, adc_in=32767. Required: with SDU_RX_SAT_EN, 65535; without it, 131068 mod 2^17 = -4.
REQ-037 Abort/reset: abort in pass 2 of 3, then a new run with rec_len=2, num_avg=1, adc_in=9,9. Required: rx_data 9,9 with no stale contribution; likewise for reset asserted mid-PLAYBACK.
REQ-038 Illegal/ignored inputs: start with rec_len=0 or num_avg=0 leaves busy=0; start pulsed during RECORD changes no counts.
